// File: rtl/flattening_stream_layer.sv
// Flattens NumOfImages interleaved feature maps into one image-major frame and
// streams it out in OutWidth-element beats; two frame banks let fill and drain overlap.
module flattening_stream_layer #(
  parameter int BitSize     = 4,
  parameter int ImageSize   = 4,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2,
  parameter int OutWidth    = 4
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic [NumOfImages-1:0]        in_valid_i,
  input  logic [NumOfInputs*BitSize-1:0] in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [OutWidth*BitSize-1:0]   out_data_o,
  output logic                          out_last_o,
  output logic                          err_overflow_o
);

  localparam int TotalElems = NumOfImages * ImageSize;
  localparam int NumBeats   = (TotalElems + OutWidth - 1) / OutWidth;
  localparam int PadElems   = NumBeats * OutWidth;
  localparam int PcW        = $clog2(ImageSize + 1);
  localparam int BcW        = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int RkW        = $clog2(NumOfImages + 1);

  logic [BitSize-1:0]          bank_q [2][TotalElems];
  logic [BitSize-1:0]          bank_d [2][TotalElems];
  logic [PcW-1:0]              pc_q [NumOfImages];
  logic [PcW-1:0]              pc_d [NumOfImages];
  logic [1:0]                  bank_full_q, bank_full_d;
  logic                        fill_sel_q, fill_sel_d;
  logic                        drain_sel_q, drain_sel_d;
  logic [BcW-1:0]              beat_cnt_q, beat_cnt_d;
  logic                        in_ready_q, in_ready_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [OutWidth*BitSize-1:0] out_data_q, out_data_d;
  logic                        err_q, err_d;

  logic                        accept_s;
  logic                        frame_done_s;
  logic                        take_s;
  logic                        full_s;
  logic [RkW-1:0]              rank_s;
  logic [BitSize-1:0]          pix_s;
  logic                        hs_s;
  logic                        last_hs_s;
  logic                        sel_s;
  logic [BitSize-1:0]          rd_flat_s [PadElems];

  // Fill side: route the lowest-ranked valid images onto lanes and write pixels.
  always_comb begin
    bank_d       = bank_q;
    pc_d         = pc_q;
    err_d        = err_q;
    rank_s       = '0;
    pix_s        = '0;
    take_s       = 1'b0;
    full_s       = 1'b0;
    frame_done_s = 1'b1;
    accept_s     = in_ready_q & (|in_valid_i);
    for (int m = 0; m < NumOfImages; m++) begin
      // Lane index equals the number of set valid bits below image m.
      pix_s  = BitSize'(in_data_i >> (BitSize * int'(rank_s)));
      take_s = accept_s & in_valid_i[m] & (int'(rank_s) < NumOfInputs);
      full_s = (pc_q[m] == PcW'(ImageSize));
      rank_s = rank_s + RkW'(in_valid_i[m]);
      err_d  = err_d | (take_s & full_s);
      for (int p = 0; p < ImageSize; p++) begin
        bank_d[fill_sel_q][m*ImageSize+p] =
          (take_s && !full_s && (pc_q[m] == PcW'(p))) ? pix_s : bank_d[fill_sel_q][m*ImageSize+p];
      end
      pc_d[m] = pc_q[m] + PcW'(take_s & ~full_s);
    end
    for (int m = 0; m < NumOfImages; m++) begin
      frame_done_s = frame_done_s & (pc_d[m] == PcW'(ImageSize));
    end
    for (int m = 0; m < NumOfImages; m++) begin
      pc_d[m] = frame_done_s ? '0 : pc_d[m];
    end
  end

  // Drain side: bank bookkeeping, beat counting and next registered outputs.
  always_comb begin
    hs_s        = out_valid_q & out_ready_i;
    last_hs_s   = hs_s & (beat_cnt_q == BcW'(NumBeats - 1));
    beat_cnt_d  = last_hs_s ? '0 : (hs_s ? beat_cnt_q + BcW'(1) : beat_cnt_q);
    bank_full_d = bank_full_q;
    bank_full_d[drain_sel_q] = bank_full_q[drain_sel_q] & ~last_hs_s;
    bank_full_d[fill_sel_q]  = bank_full_d[fill_sel_q] | frame_done_s;
    fill_sel_d  = fill_sel_q ^ frame_done_s;
    drain_sel_d = drain_sel_q ^ last_hs_s;
    in_ready_d  = ~bank_full_d[fill_sel_d];
    out_valid_d = bank_full_d[drain_sel_d];
    out_last_d  = out_valid_d & (beat_cnt_d == BcW'(NumBeats - 1));
    for (int i = 0; i < PadElems; i++) begin
      rd_flat_s[i] = '0;
    end
    for (int i = 0; i < TotalElems; i++) begin
      rd_flat_s[i] = bank_d[drain_sel_d][i];
    end
    sel_s      = 1'b0;
    out_data_d = '0;
    for (int b = 0; b < NumBeats; b++) begin
      sel_s = out_valid_d & (beat_cnt_d == BcW'(b));
      for (int e = 0; e < OutWidth; e++) begin
        out_data_d[e*BitSize +: BitSize] =
          out_data_d[e*BitSize +: BitSize] | ({BitSize{sel_s}} & rd_flat_s[b*OutWidth+e]);
      end
    end
  end

  // State and output registers; reset discards both banks and any partial frame.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < TotalElems; i++) begin
          bank_q[s][i] <= '0;
        end
      end
      for (int m = 0; m < NumOfImages; m++) begin
        pc_q[m] <= '0;
      end
      bank_full_q <= 2'b00;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      pc_q        <= pc_d;
      bank_full_q <= bank_full_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_last_o     = out_last_q;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_flattening_stream_layer.sv
// Directed bench for flattening_stream_layer: a queue-based frame model is checked
// every cycle against two instances (OutWidth 4 and 5), plus literal beat checks.
module tb_flattening_stream_layer;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [3:0]  in_valid = 4'b0000;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b0;

  logic        in_ready4, out_valid4, out_last4, err4;
  logic [15:0] out_data4;
  logic        in_ready5, out_valid5, out_last5, err5;
  logic [19:0] out_data5;

  flattening_stream_layer #(.OutWidth(4)) dut4 (
    .clk(clk), .res_n(res_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready4), .out_valid_o(out_valid4), .out_ready_i(out_ready),
    .out_data_o(out_data4), .out_last_o(out_last4), .err_overflow_o(err4)
  );

  flattening_stream_layer #(.OutWidth(5)) dut5 (
    .clk(clk), .res_n(res_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready5), .out_valid_o(out_valid5), .out_ready_i(out_ready),
    .out_data_o(out_data5), .out_last_o(out_last5), .err_overflow_o(err5)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int hs_count = 0;

  // Model: completed frames waiting to drain, plus per-image pixel lists being filled.
  logic [63:0] m_frames[$];
  int          m_cnt [4];
  logic [3:0]  m_pix [4][4];
  int          m_beat;
  logic        m_err;

  logic [15:0] e4 [4];
  logic [19:0] e5 [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] exp_beat(input logic [63:0] fr, input int b, input int ow);
    logic [19:0] r;
    r = '0;
    for (int e = 0; e < ow; e++) begin
      int idx;
      idx = b * ow + e;
      if (idx < 16) r[e*4 +: 4] = fr[idx*4 +: 4];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_frames.delete();
    for (int m = 0; m < 4; m++) m_cnt[m] = 0;
    m_beat = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit rdy, vld, done;
    int lanes;
    logic [3:0] v;
    logic [63:0] fr;
    if (!res_n) begin
      model_reset();
      return;
    end
    rdy = (m_frames.size() < 2);
    vld = (m_frames.size() > 0);
    if (vld && out_ready) begin
      if (m_beat == 3) begin
        m_beat = 0;
        m_frames.delete(0);
      end else begin
        m_beat++;
      end
    end
    if (rdy && (in_valid != 4'b0000)) begin
      lanes = 0;
      for (int m = 0; m < 4; m++) begin
        if (in_valid[m] && lanes < 2) begin
          v = (lanes == 0) ? in_data[3:0] : in_data[7:4];
          lanes++;
          if (m_cnt[m] < 4) begin
            m_pix[m][m_cnt[m]] = v;
            m_cnt[m]++;
          end else begin
            m_err = 1'b1;
          end
        end
      end
      done = 1'b1;
      for (int m = 0; m < 4; m++) if (m_cnt[m] != 4) done = 1'b0;
      if (done) begin
        fr = '0;
        for (int m = 0; m < 4; m++)
          for (int p = 0; p < 4; p++) fr[(m*4+p)*4 +: 4] = m_pix[m][p];
        m_frames.push_back(fr);
        for (int m = 0; m < 4; m++) m_cnt[m] = 0;
      end
    end
  endtask

  task automatic compare();
    bit exp_rdy, exp_v, exp_last;
    logic [19:0] b4, b5;
    if (!res_n) model_reset();
    exp_rdy  = (m_frames.size() < 2);
    exp_v    = (m_frames.size() > 0);
    exp_last = exp_v && (m_beat == 3);
    check("in_ready4", in_ready4, exp_rdy);
    check("in_ready5", in_ready5, exp_rdy);
    check("out_valid4", out_valid4, exp_v);
    check("out_valid5", out_valid5, exp_v);
    check("out_last4", out_last4, exp_last);
    check("out_last5", out_last5, exp_last);
    check("err4", err4, m_err);
    check("err5", err5, m_err);
    if (exp_v) begin
      b4 = exp_beat(m_frames[0], m_beat, 4);
      b5 = exp_beat(m_frames[0], m_beat, 5);
      check("out_data4", out_data4, b4[15:0]);
      check("out_data5", out_data5, b5);
    end
    if (out_valid4 && out_ready) hs_count++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] lo, input logic [3:0] hi);
    in_valid = v;
    in_data  = {hi, lo};
    cyc();
  endtask

  // off < 0 sends the constant per-image frame {1,2,3,4}; otherwise values vary per pixel.
  task automatic send_frame(input int off);
    for (int i = 0; i < 4; i++) begin
      if (off < 0) begin
        drive(4'b0011, 4'd1, 4'd2);
        drive(4'b1100, 4'd3, 4'd4);
      end else begin
        drive(4'b0011, 4'(off + i), 4'(off + i + 4));
        drive(4'b1100, 4'(off + i + 8), 4'(off + i + 12));
      end
    end
    in_valid = 4'b0000;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int k;
    k = 0;
    while (out_valid4 && k < limit) begin
      cyc();
      k++;
    end
    check(name, out_valid4, 1'b0);
  endtask

  task automatic check_plain_frame(input string tag);
    check({tag, "_valid"}, out_valid4, 1'b1);
    for (int b = 0; b < 4; b++) begin
      check({tag, "_beat4"}, out_data4, e4[b]);
      check({tag, "_beat5"}, out_data5, e5[b]);
      check({tag, "_last"}, out_last4, (b == 3));
      cyc();
    end
    check({tag, "_idle"}, out_valid4, 1'b0);
  endtask

  initial begin
    int hs0;
    e4[0] = 16'h1111; e4[1] = 16'h2222; e4[2] = 16'h3333; e4[3] = 16'h4444;
    e5[0] = 20'h21111; e5[1] = 20'h33222; e5[2] = 20'h44433; e5[3] = 20'h00004;

    res_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) cyc();
    check("rst_in_ready", in_ready4, 1'b1);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_out_data4", out_data4, 16'h0000);
    check("rst_out_data5", out_data5, 20'h00000);
    check("rst_out_last", out_last4, 1'b0);
    check("rst_err", err4, 1'b0);
    res_n = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Basic frame: out_valid one cycle after the eighth accepted cycle.
    send_frame(-1);
    check_plain_frame("t1");
    check("t1_err", err4, 1'b0);

    // Backpressure: two frames fill both banks, the third is ignored.
    out_ready = 1'b0;
    send_frame(1);
    check("t2_ready_f1", in_ready4, 1'b1);
    send_frame(2);
    check("t2_ready_full", in_ready4, 1'b0);
    send_frame(5);
    check("t2_ready_still_full", in_ready4, 1'b0);
    check("t2_f1_beat0_stalled", out_data4, 16'h4321);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("t2_ready_before_release", in_ready4, 1'b0);
    cyc();
    check("t2_ready_after_release", in_ready4, 1'b1);
    check("t2_f2_beat0", out_data4, 16'h5432);
    repeat (4) cyc();
    check("t2_idle", out_valid4, 1'b0);

    // Toggling out_ready while two frames stream in.
    hs0 = hs_count;
    out_ready = 1'b0;
    fork
      begin
        send_frame(3);
        send_frame(7);
      end
      begin
        repeat (16) begin
          out_ready = ~out_ready;
          cyc();
        end
      end
    join
    out_ready = 1'b1;
    wait_idle("t3_drained", 40);
    check("t3_beat_count", hs_count - hs0, 8);

    // Overflow on image 0; bit 3 of 4'b1110 exceeds the two lanes and is ignored.
    check("t4_err_before", err4, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0001, 4'(5 + i), 4'd0);
    drive(4'b0001, 4'd15, 4'd0);
    in_valid = 4'b0000;
    check("t4_err_set", err4, 1'b1);
    check("t4_err_set5", err5, 1'b1);
    for (int i = 0; i < 4; i++) drive(4'b1110, 4'(9 + i), 4'(i));
    for (int i = 0; i < 4; i++) drive(4'b1000, 4'(15 - i), 4'd0);
    in_valid = 4'b0000;
    check("t4_valid", out_valid4, 1'b1);
    check("t4_beat0", out_data4, 16'h8765);
    cyc();
    check("t4_beat1", out_data4, 16'hCBA9);
    cyc();
    check("t4_beat2", out_data4, 16'h3210);
    cyc();
    check("t4_beat3", out_data4, 16'hCDEF);
    check("t4_last", out_last4, 1'b1);
    cyc();
    check("t4_err_sticky", err4, 1'b1);

    // Reset in the middle of a drain, then a fresh frame from beat 0.
    send_frame(-1);
    cyc();
    cyc();
    res_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid4, 1'b0);
    check("t5_rst_data4", out_data4, 16'h0000);
    check("t5_rst_data5", out_data5, 20'h00000);
    check("t5_rst_last", out_last4, 1'b0);
    check("t5_rst_err", err4, 1'b0);
    check("t5_rst_ready", in_ready4, 1'b1);
    cyc();
    res_n = 1'b1;
    cyc();
    check("t5_post_ready", in_ready4, 1'b1);
    check("t5_post_valid", out_valid4, 1'b0);
    send_frame(-1);
    check_plain_frame("t5");

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
